// File: rtl/prom_loader.sv
// UART-fed PROM loader: parses SYNC/ADDR/COUNT/payload/CSUM frames and issues
// one PROM write per assembled little-endian word, with checksum and idle timeout.
module prom_loader #(
  parameter int WORD_BYTES     = 2,
  parameter int ROM_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ADDR_BITS     = $clog2(ROM_WORDS),
  localparam int DATA_BITS     = 8 * WORD_BYTES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_ready_i,
  output logic                 wr_en_o,
  output logic [ADDR_BITS-1:0] wr_addr_o,
  output logic [DATA_BITS-1:0] wr_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           error_o
);

  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM} state_t;

  state_t               state_reg;
  logic [1:0]           rst_sync_reg;
  logic                 rst_core_n;
  logic [ADDR_BITS-1:0] ptr_reg;
  logic [DATA_BITS-1:0] word_reg;
  logic [DATA_BITS-1:0] word_next;
  logic [1:0]           byte_idx_reg;
  logic [7:0]           words_left_reg;
  logic [7:0]           csum_reg;
  logic [7:0]           csum_next;
  logic [TO_BITS-1:0]   idle_cnt_reg;
  logic                 wr_en_reg;
  logic [ADDR_BITS-1:0] wr_addr_reg;
  logic [DATA_BITS-1:0] wr_data_reg;
  logic                 done_reg;
  logic [1:0]           error_reg;

  // Assertion clears everything at once; release reaches the core two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_core_n = rst_sync_reg[1];

  assign csum_next = csum_reg + rx_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? rx_data_i : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      word_reg       <= '0;
      byte_idx_reg   <= '0;
      words_left_reg <= '0;
      csum_reg       <= '0;
      idle_cnt_reg   <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 2'd0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (!enable_i) begin
        state_reg    <= IDLE;
        idle_cnt_reg <= '0;
      end else if (rx_ready_i) begin
        idle_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (rx_data_i == SYNC_BYTE) begin
              state_reg <= ADDR;
              error_reg <= 2'd0;
              csum_reg  <= '0;
            end
          end
          ADDR: begin
            ptr_reg   <= rx_data_i[ADDR_BITS-1:0];
            csum_reg  <= csum_next;
            state_reg <= COUNT;
          end
          COUNT: begin
            words_left_reg <= rx_data_i;
            csum_reg       <= csum_next;
            byte_idx_reg   <= '0;
            state_reg      <= (rx_data_i == 8'd0) ? CSUM : DATA;
          end
          DATA: begin
            csum_reg <= csum_next;
            word_reg <= word_next;
            if (byte_idx_reg == 2'(WORD_BYTES - 1)) begin
              byte_idx_reg   <= '0;
              wr_en_reg      <= 1'b1;
              wr_addr_reg    <= ptr_reg;
              wr_data_reg    <= word_next;
              ptr_reg        <= ptr_reg + 1'b1;
              words_left_reg <= words_left_reg - 8'd1;
              if (words_left_reg == 8'd1) state_reg <= CSUM;
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
          CSUM: begin
            state_reg <= IDLE;
            if (csum_next == 8'd0) done_reg  <= 1'b1;
            else                   error_reg <= 2'd1;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        if (idle_cnt_reg == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
          state_reg    <= IDLE;
          error_reg    <= 2'd2;
          idle_cnt_reg <= '0;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign wr_en_o   = wr_en_reg;
  assign wr_addr_o = wr_addr_reg;
  assign wr_data_o = wr_data_reg;
  assign busy_o    = (state_reg != IDLE);
  assign done_o    = done_reg;
  assign error_o   = error_reg;

endmodule

// File: tb/tb_prom_loader.sv
// Scoreboard bench for prom_loader: expected PROM writes are queued as frames are
// driven and popped as wr_en_o strobes appear.
module tb_prom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_i;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  error_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];

  prom_loader #(.WORD_BYTES(2), .ROM_WORDS(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_o) begin
      $display("write addr=%0d data=%04h", wr_addr_o, wr_data_o);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_en_o), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e[19:16]));
        check("wr_data", 32'(wr_data_o), 32'(e[15:0]));
      end
    end
    if (done_o) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_i  = b;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  // Builds a frame of up to two words; the checksum is the two's complement of the byte sum.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt,
                            input logic [15:0] w0, input logic [15:0] w1, input bit bad);
    logic [7:0]  sum;
    logic [7:0]  csum;
    logic [3:0]  ptr;
    logic [15:0] w;
    int d0;
    sum = addr + cnt;
    ptr = addr[3:0];
    for (int i = 0; i < int'(cnt); i++) begin
      w = (i == 0) ? w0 : w1;
      sum = sum + w[7:0] + w[15:8];
      exp_q.push_back({ptr, w});
      ptr = ptr + 4'd1;
    end
    csum = 8'h00 - sum;
    if (bad) csum = csum - 8'd1;
    d0 = done_cnt;
    send_byte(8'hA5);
    check("err_clear_on_sync", 32'(error_o), 32'd0);
    check("busy_after_sync", 32'(busy_o), 32'd1);
    send_byte(addr);
    send_byte(cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      w = (i == 0) ? w0 : w1;
      send_byte(w[7:0]);
      send_byte(w[15:8]);
    end
    send_byte(csum);
    repeat (3) @(negedge clk);
    $display("frame addr=%02h count=%0d csum=%02h done=%0d error=%0d", addr, cnt, csum, done_cnt - d0, error_o);
    check("done_pulses", 32'(done_cnt - d0), bad ? 32'd0 : 32'd1);
    check("frame_error", 32'(error_o), bad ? 32'd1 : 32'd0);
    check("busy_end", 32'(busy_o), 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   32'(wr_en_o),   32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data_o), 32'd0);
    check({tag, "_busy"},    32'(busy_o),    32'd0);
    check({tag, "_done"},    32'(done_o),    32'd0);
    check({tag, "_error"},   32'(error_o),   32'd0);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; enable_i = 1'b1; rx_data_i = 8'h00; rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic load and wrap-around
    send_frame(8'h03, 8'd2, 16'h1234, 16'h5678, 1'b0);
    send_frame(8'h0F, 8'd2, 16'h1111, 16'h2222, 1'b0);
    // bad checksum: writes still happen, error latched
    send_frame(8'h03, 8'd2, 16'h1234, 16'h5678, 1'b1);

    // disabled: bytes ignored, error held
    enable_i = 1'b0;
    send_byte(8'hA5);
    check("disabled_busy", 32'(busy_o), 32'd0);
    check("disabled_err_hold", 32'(error_o), 32'd1);
    enable_i = 1'b1;

    // noise then empty frame
    send_byte(8'h00);
    send_byte(8'hFF);
    check("noise_busy", 32'(busy_o), 32'd0);
    send_frame(8'h00, 8'd0, 16'h0000, 16'h0000, 1'b0);

    // timeout after exactly 16 idle cycles
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (15) @(negedge clk);
    check("timeout_not_yet", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("timeout_busy", 32'(busy_o), 32'd0);
    check("timeout_error", 32'(error_o), 32'd2);
    repeat (4) @(negedge clk);
    check("timeout_error_hold", 32'(error_o), 32'd2);
    send_frame(8'h05, 8'd1, 16'hBEEF, 16'h0000, 1'b0);

    // byte arriving on the expiry cycle cancels the timeout
    exp_q.push_back({4'd3, 16'h1234});
    exp_q.push_back({4'd4, 16'h5678});
    d0 = done_cnt;
    send_byte(8'hA5);
    repeat (14) @(negedge clk);
    send_byte(8'h03);
    check("expiry_byte_busy", 32'(busy_o), 32'd1);
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'hE7);
    repeat (3) @(negedge clk);
    check("expiry_done", 32'(done_cnt - d0), 32'd1);
    check("expiry_error", 32'(error_o), 32'd0);
    check("expiry_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-DATA, then a full frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02); send_byte(8'h34);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h03, 8'd2, 16'h1234, 16'h5678, 1'b0);

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
